mem_access_unit: RTL and testbench

Initiator side of the unified instruction/data memory port of the multicycle RISC-V core. It accepts one fetch, load or store request at a time from the multicycle control unit and drives the memory's WrEn/RdEn/addr/WrData. It captures MemData into the instruction register (fetch) or the load-data path (load). Byte and halfword stores are done as read-modify-write, because the memory is word-only.

---
 rtl/riscv_mem_pkg.sv | 28 ++
 rtl/mem_lane_align.sv | 48 ++++
 rtl/mem_access_unit.sv | 134 +++++++++++++
 tb/tb_mem_access_unit.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared types for the unified instruction/data memory port: access sizes, FSM states,
// and the default memory geometry.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    SzB = 2'b00,
    SzH = 2'b01,
    SzW = 2'b10,
    SzX = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StRmwRd,
    StWrite,
    StResp
  } state_e;

  localparam int unsigned MemWordsDefault = 64;
  localparam int unsigned AddrWDefault    = 32;

  // Flags the illegal size code and any lane offset that does not fit the access size.
  function automatic logic size_misaligned(size_e size, logic [1:0] lo);
    return (size == SzX) || ((size == SzH) && lo[0]) || ((size == SzW) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane handling: extracts and extends load data from a memory word, and merges
// sub-word store data into the old word for read-modify-write.
module mem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [31:0] rd_word_i,
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  input  size_e       size_i,
  input  logic [1:0]  lane_i,
  input  logic        unsigned_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    rd_byte = 8'h00;
    unique case (lane_i)
      2'b00:   rd_byte = rd_word_i[7:0];
      2'b01:   rd_byte = rd_word_i[15:8];
      2'b10:   rd_byte = rd_word_i[23:16];
      default: rd_byte = rd_word_i[31:24];
    endcase
    rd_half = lane_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];
  end

  always_comb begin
    load_data_o = rd_word_i;
    unique case (size_i)
      SzB:     load_data_o = {{24{~unsigned_i & rd_byte[7]}}, rd_byte};
      SzH:     load_data_o = {{16{~unsigned_i & rd_half[15]}}, rd_half};
      default: load_data_o = rd_word_i;
    endcase
  end

  always_comb begin
    store_word_o = old_word_i;
    unique case (size_i)
      SzB:     store_word_o[8*lane_i +: 8] = wdata_i[7:0];
      SzH:     store_word_o[16*lane_i[1] +: 16] = wdata_i[15:0];
      default: store_word_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator for the unified memory port: one fetch/load/store at a time, with sub-word stores
// done as read-modify-write against the word-only memory.
module mem_access_unit
  import riscv_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MemWordsDefault,
  parameter int unsigned ADDR_W    = AddrWDefault
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_fetch_i,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic              rsp_err_o,
  output logic [31:0]       rsp_rdata_o,
  output logic [31:0]       ir_o,
  output logic              mem_WrEn_o,
  output logic              mem_RdEn_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_WrData_o,
  input  logic [31:0]       mem_MemData_i
);

  localparam logic [ADDR_W-3:0] MemWordsW = (ADDR_W-2)'(MEM_WORDS);

  state_e            state_q;
  logic              fetch_q;
  logic              we_q;
  logic              unsigned_q;
  logic              err_q;
  size_e             size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       old_q;
  logic [31:0]       rdata_q;
  logic [31:0]       ir_q;

  size_e       req_size;
  logic        req_bad;
  logic [31:0] load_data;
  logic [31:0] store_word;

  always_comb begin
    req_size = size_e'(req_size_i);
    req_bad  = size_misaligned(req_size, req_addr_i[1:0])
            || (req_addr_i[ADDR_W-1:2] >= MemWordsW)
            || (req_fetch_i && (req_we_i || (req_size != SzW)));
  end

  mem_lane_align u_align (
    .rd_word_i    (mem_MemData_i),
    .old_word_i   (old_q),
    .wdata_i      (wdata_q),
    .size_i       (size_q),
    .lane_i       (addr_q[1:0]),
    .unsigned_i   (unsigned_q),
    .load_data_o  (load_data),
    .store_word_o (store_word)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      fetch_q    <= 1'b0;
      we_q       <= 1'b0;
      unsigned_q <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= SzB;
      addr_q     <= '0;
      wdata_q    <= '0;
      old_q      <= '0;
      rdata_q    <= '0;
      ir_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            fetch_q    <= req_fetch_i;
            we_q       <= req_we_i;
            unsigned_q <= req_unsigned_i;
            size_q     <= req_size;
            addr_q     <= req_addr_i;
            wdata_q    <= req_wdata_i;
            err_q      <= req_bad;
            if (req_bad) begin
              state_q <= StResp;
            end else if (!req_we_i) begin
              state_q <= StRead;
            end else if (req_size == SzW) begin
              state_q <= StWrite;
            end else begin
              state_q <= StRmwRd;
            end
          end
        end
        StRead: begin
          rdata_q <= load_data;
          if (fetch_q) begin
            ir_q <= mem_MemData_i;
          end
          state_q <= StResp;
        end
        StRmwRd: begin
          old_q   <= mem_MemData_i;
          state_q <= StWrite;
        end
        StWrite: state_q <= StResp;
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Enables decode from the state register alone so they drop with the asynchronous reset.
  assign req_ready_o  = (state_q == StIdle);
  assign rsp_valid_o  = (state_q == StResp);
  assign rsp_err_o    = (state_q == StResp) && err_q;
  assign mem_RdEn_o   = (state_q == StRead) || (state_q == StRmwRd);
  assign mem_WrEn_o   = (state_q == StWrite);
  assign mem_addr_o   = (state_q == StIdle) ? '0 : {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_WrData_o = (state_q == StWrite) ? store_word : 32'h0;
  assign rsp_rdata_o  = rdata_q;
  assign ir_o         = ir_q;

  logic unused_we;
  assign unused_we = we_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, reset/back-to-back sequences, and
// randomized requests checked against a word-array reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_fetch = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] ir;
  logic        mem_WrEn;
  logic        mem_RdEn;
  logic [31:0] mem_addr;
  logic [31:0] mem_WrData;
  logic [31:0] mem_MemData;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_WORDS(64), .ADDR_W(32)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_fetch_i    (req_fetch),
    .req_we_i       (req_we),
    .req_size_i     (req_size),
    .req_unsigned_i (req_unsigned),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .rsp_valid_o    (rsp_valid),
    .rsp_err_o      (rsp_err),
    .rsp_rdata_o    (rsp_rdata),
    .ir_o           (ir),
    .mem_WrEn_o     (mem_WrEn),
    .mem_RdEn_o     (mem_RdEn),
    .mem_addr_o     (mem_addr),
    .mem_WrData_o   (mem_WrData),
    .mem_MemData_i  (mem_MemData)
  );

  // Word-only memory seen by the DUT, with a bench-side preload port.
  logic [31:0] tb_mem [64];
  logic        ld_en = 1'b0;
  logic [5:0]  ld_idx = 6'd0;
  logic [31:0] ld_val = 32'h0;

  assign mem_MemData = (mem_addr < 32'd256) ? tb_mem[mem_addr[7:2]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (ld_en) tb_mem[ld_idx] <= ld_val;
    else if (mem_WrEn && mem_addr < 32'd256) tb_mem[mem_addr[7:2]] <= mem_WrData;
  end

  int          rd_total = 0;
  int          wr_total = 0;
  logic [31:0] last_wdata = 32'h0;
  logic [31:0] last_en_addr = 32'h0;
  bit          both_seen = 1'b0;

  always @(negedge clk) begin
    if (mem_RdEn) begin rd_total++; last_en_addr = mem_addr; end
    if (mem_WrEn) begin wr_total++; last_en_addr = mem_addr; last_wdata = mem_WrData; end
    if (mem_RdEn && mem_WrEn) both_seen = 1'b1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%h expected=%h", nm, idx, act, exp);
    end
  endtask

  // Reference model: flat word array plus the architectural response rules.
  logic [31:0] ref_mem [64];
  logic [31:0] exp_rdata = 32'h0;
  logic [31:0] exp_ir = 32'h0;

  function automatic void model(input bit f, input bit w, input bit [1:0] s, input bit u,
                                input bit [31:0] a, input bit [31:0] d, output bit err,
                                output int lat, output int nrd, output int nwr,
                                output bit [31:0] wword);
    int unsigned idx;
    int unsigned off;
    bit [31:0]   old;
    bit [31:0]   v;
    bit [31:0]   mask;
    idx   = a / 4;
    off   = a % 4;
    wword = 32'h0;
    err   = (s == 2'd3) || (s == 2'd1 && (a % 2) != 0) || (s == 2'd2 && off != 0)
         || (f && (w || s != 2'd2)) || (idx >= 64);
    if (err) begin
      lat = 1; nrd = 0; nwr = 0;
      return;
    end
    old = ref_mem[idx];
    if (!w) begin
      lat = 2; nrd = 1; nwr = 0;
      if (s == 2'd0) begin
        v = (old >> (8 * off)) & 32'hFF;
        if (!u && v >= 32'h80) v = v + 32'hFFFF_FF00;
      end else if (s == 2'd1) begin
        v = (old >> (8 * off)) & 32'hFFFF;
        if (!u && v >= 32'h8000) v = v + 32'hFFFF_0000;
      end else begin
        v = old;
      end
      exp_rdata = v;
      if (f) exp_ir = old;
    end else if (s == 2'd2) begin
      lat = 2; nrd = 0; nwr = 1;
      wword = d;
      ref_mem[idx] = d;
    end else begin
      lat = 3; nrd = 1; nwr = 1;
      mask  = (s == 2'd0) ? 32'hFF : 32'hFFFF;
      wword = (old & ~(mask << (8 * off))) | ((d & mask) << (8 * off));
      ref_mem[idx] = wword;
    end
  endfunction

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    ld_en  = 1'b1;
    ld_idx = idx[5:0];
    ld_val = val;
    ref_mem[idx] = val;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic xact(input bit f, input bit w, input bit [1:0] s, input bit u,
                      input bit [31:0] a, input bit [31:0] d, output int lat, output bit e,
                      output bit [31:0] rd, output int nrd, output int nwr);
    int rd0;
    int wr0;
    @(negedge clk);
    rd0 = rd_total;
    wr0 = wr_total;
    req_fetch = f; req_we = w; req_size = s; req_unsigned = u;
    req_addr = a; req_wdata = d; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; e = 1'b0; rd = 32'h0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = k; e = rsp_err; rd = rsp_rdata;
        break;
      end
    end
    nrd = rd_total - rd0;
    nwr = wr_total - wr0;
  endtask

  typedef struct {
    bit        f;
    bit        w;
    bit [1:0]  s;
    bit        u;
    bit [31:0] a;
    bit [31:0] d;
    bit        e;
    int        lat;
    bit [31:0] rdata;
    int        nrd;
    int        nwr;
    bit [31:0] wword;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int        lat, nrd, nwr, m_lat, m_nrd, m_nwr, bad_words;
    bit        e, m_err;
    bit [31:0] rd, m_wword;
    bit [5:0]  mask;
    bit        rdy3, rsp_seen;

    tbl[0]  = '{1, 0, 2'd2, 0, 32'd40, 32'h0, 0, 2, 32'h0094_8663, 1, 0, 32'h0};
    tbl[1]  = '{0, 0, 2'd0, 0, 32'h2D, 32'h0, 0, 2, 32'hFFFF_FF80, 1, 0, 32'h0};
    tbl[2]  = '{0, 0, 2'd0, 1, 32'h2D, 32'h0, 0, 2, 32'h0000_0080, 1, 0, 32'h0};
    tbl[3]  = '{0, 0, 2'd1, 1, 32'h2E, 32'h0, 0, 2, 32'h0000_1234, 1, 0, 32'h0};
    tbl[4]  = '{0, 0, 2'd1, 0, 32'h2C, 32'h0, 0, 2, 32'hFFFF_80FF, 1, 0, 32'h0};
    tbl[5]  = '{0, 1, 2'd0, 0, 32'h21, 32'hAB, 0, 3, 32'hFFFF_80FF, 1, 1, 32'h1111_AB11};
    tbl[6]  = '{0, 0, 2'd2, 0, 32'h20, 32'h0, 0, 2, 32'h1111_AB11, 1, 0, 32'h0};
    tbl[7]  = '{0, 1, 2'd2, 0, 32'h22, 32'h55, 1, 1, 32'h1111_AB11, 0, 0, 32'h0};
    tbl[8]  = '{1, 1, 2'd2, 0, 32'd40, 32'h0, 1, 1, 32'h1111_AB11, 0, 0, 32'h0};
    tbl[9]  = '{0, 0, 2'd2, 0, 32'h100, 32'h0, 1, 1, 32'h1111_AB11, 0, 0, 32'h0};
    tbl[10] = '{0, 0, 2'd1, 0, 32'h21, 32'h0, 1, 1, 32'h1111_AB11, 0, 0, 32'h0};
    tbl[11] = '{0, 0, 2'd3, 0, 32'h24, 32'h0, 1, 1, 32'h1111_AB11, 0, 0, 32'h0};
    tbl[12] = '{0, 1, 2'd1, 0, 32'h22, 32'hBEEF_5678, 0, 3, 32'h1111_AB11, 1, 1, 32'h5678_AB11};
    tbl[13] = '{0, 0, 2'd2, 0, 32'h20, 32'h0, 0, 2, 32'h5678_AB11, 1, 0, 32'h0};

    // Reset state, checked while reset is held.
    repeat (2) @(negedge clk);
    chk("rst_ready", 0, 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 0, 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 0, 32'(rsp_err), 32'd0);
    chk("rst_rdata", 0, rsp_rdata, 32'h0);
    chk("rst_ir", 0, ir, 32'h0);
    chk("rst_enables", 0, {30'd0, mem_WrEn, mem_RdEn}, 32'd0);
    chk("rst_addr", 0, mem_addr, 32'h0);
    chk("rst_wrdata", 0, mem_WrData, 32'h0);

    for (int i = 0; i < 64; i++) begin
      if (i == 8)       preload(i, 32'h1111_1111);
      else if (i == 10) preload(i, 32'h0094_8663);
      else if (i == 11) preload(i, 32'h1234_80FF);
      else              preload(i, 32'(i) * 32'h0101_0101);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 14; i++) begin
      model(tbl[i].f, tbl[i].w, tbl[i].s, tbl[i].u, tbl[i].a, tbl[i].d,
            m_err, m_lat, m_nrd, m_nwr, m_wword);
      xact(tbl[i].f, tbl[i].w, tbl[i].s, tbl[i].u, tbl[i].a, tbl[i].d, lat, e, rd, nrd, nwr);
      chk("tbl_err", i, 32'(e), 32'(tbl[i].e));
      chk("tbl_lat", i, 32'(lat), 32'(tbl[i].lat));
      chk("tbl_rdata", i, rd, tbl[i].rdata);
      chk("tbl_rd_cycles", i, 32'(nrd), 32'(tbl[i].nrd));
      chk("tbl_wr_cycles", i, 32'(nwr), 32'(tbl[i].nwr));
      chk("tbl_ir", i, ir, exp_ir);
      if (tbl[i].nwr > 0) chk("tbl_wrdata", i, last_wdata, tbl[i].wword);
      if (tbl[i].nrd + tbl[i].nwr > 0) chk("tbl_mem_addr", i, last_en_addr, tbl[i].a & ~32'd3);
    end
    chk("tbl_ir_final", 0, ir, 32'h0094_8663);

    // Reset during the read half of a sub-word store.
    @(negedge clk);
    req_fetch = 0; req_we = 1; req_size = 2'd0; req_unsigned = 0;
    req_addr = 32'h21; req_wdata = 32'hCD; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #2 chk("rmw_rden_before_rst", 0, 32'(mem_RdEn), 32'd1);
    rst_n = 1'b0;
    #1 chk("rmw_rden_async_drop", 0, 32'(mem_RdEn), 32'd0);
    exp_ir = 32'h0;
    exp_rdata = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rsp_seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen = 1'b1;
    end
    chk("rst_mid_no_rsp", 0, 32'(rsp_seen), 32'd0);
    chk("rst_mid_ready", 0, 32'(req_ready), 32'd1);
    chk("rst_mid_ir", 0, ir, 32'h0);

    // Request held valid across two transactions.
    model(0, 0, 2'd2, 0, 32'h2C, 32'h0, m_err, m_lat, m_nrd, m_nwr, m_wword);
    model(0, 0, 2'd2, 0, 32'h2C, 32'h0, m_err, m_lat, m_nrd, m_nwr, m_wword);
    @(negedge clk);
    req_fetch = 0; req_we = 0; req_size = 2'd2; req_addr = 32'h2C; req_valid = 1'b1;
    mask = '0;
    rdy3 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (rsp_valid) mask[k-1] = 1'b1;
      if (k == 3) rdy3 = req_ready;
      if (k == 5) req_valid = 1'b0;
    end
    chk("b2b_rsp_cycles", 0, 32'(mask), 32'b010010);
    chk("b2b_ready_gap", 0, 32'(rdy3), 32'd1);
    chk("b2b_rdata", 0, rsp_rdata, exp_rdata);

    // Randomized requests against the reference model.
    for (int i = 0; i < 64; i++) preload(i, $urandom);
    for (int i = 0; i < 250; i++) begin
      bit        f, w, u;
      bit [1:0]  s;
      bit [31:0] a, d;
      f = ($urandom % 5 == 0);
      w = f ? ($urandom % 8 == 0) : bit'($urandom % 2);
      s = (f && $urandom % 8 != 0) ? 2'd2 : 2'($urandom_range(0, 3));
      u = bit'($urandom % 2);
      a = f ? 32'($urandom_range(0, 70) * 4) : 32'($urandom_range(0, 279));
      if ($urandom % 20 == 0) a = $urandom;
      d = $urandom;
      model(f, w, s, u, a, d, m_err, m_lat, m_nrd, m_nwr, m_wword);
      xact(f, w, s, u, a, d, lat, e, rd, nrd, nwr);
      chk("rnd_err", i, 32'(e), 32'(m_err));
      chk("rnd_lat", i, 32'(lat), 32'(m_lat));
      chk("rnd_rdata", i, rd, exp_rdata);
      chk("rnd_ir", i, ir, exp_ir);
      chk("rnd_rd_cycles", i, 32'(nrd), 32'(m_nrd));
      chk("rnd_wr_cycles", i, 32'(nwr), 32'(m_nwr));
      if (m_nwr > 0) chk("rnd_wrdata", i, last_wdata, m_wword);
      if (m_nrd + m_nwr > 0) chk("rnd_mem_addr", i, last_en_addr, a & ~32'd3);
    end

    @(negedge clk);
    bad_words = 0;
    for (int i = 0; i < 64; i++) if (tb_mem[i] !== ref_mem[i]) bad_words++;
    chk("mem_image_bad_words", 0, 32'(bad_words), 32'd0);
    chk("enables_overlap", 0, 32'(both_seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
